// File: rtl/wb_sram_bank_loader.sv
// Wishbone program loader and fetch mux for NBANKS OpenRAM 1rw1r macros; CTRL gates core reset and write-protect.
// Optional feature macro: WB_READBACK_EN (port-0 SRAM reads over Wishbone).

module wb_sram_bank_loader #(
    parameter int          NBANKS    = 2,
    parameter int          ADDR_W    = 9,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    localparam int         BANK_W    = $clog2(NBANKS + 1)
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic                     core_csb_i,
    input  logic [BANK_W+ADDR_W-1:0] core_addr_i,
    output logic [31:0]              core_dat_o,
    output logic                     core_rst_no,
    output logic [NBANKS-1:0]        ram_csb0_o,
    output logic                     ram_web0_o,
    output logic [3:0]               ram_wmask0_o,
    output logic [ADDR_W-1:0]        ram_addr0_o,
    output logic [31:0]              ram_din0_o,
    input  logic [NBANKS*32-1:0]     ram_dout0_i,
    output logic [NBANKS-1:0]        ram_csb1_o,
    output logic [ADDR_W-1:0]        ram_addr1_o,
    input  logic [NBANKS*32-1:0]     ram_dout1_i
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    typedef struct packed {
        logic              we;
        logic [3:0]        sel;
        logic [BANK_W-1:0] bank;
        logic [ADDR_W-1:0] word;
        logic [31:0]       dat;
    } req_t;

    state_t              state_q, state_d;
    req_t                req_q;
    logic                wp_q, run_q, wp_d, run_d;
    logic [NBANKS-1:0]   csb0_d;
    logic                web0_d, ack_d;
    logic [3:0]          wmask0_d;
    logic [31:0]         rdata_d;
    logic [BANK_W-1:0]   in_bank, core_bank, fbank_q;
    logic                hit, accept, req_ram, req_ctrl;
    logic [NBANKS-1:0][31:0] dout1_v;
`ifdef WB_READBACK_EN
    logic [NBANKS-1:0][31:0] dout0_v;
    assign dout0_v = ram_dout0_i;
`endif
    assign dout1_v = ram_dout1_i;

    assign in_bank  = wbs_adr_i[ADDR_W+2 +: BANK_W];
    assign hit      = wbs_adr_i[31:24] == BASE_ADDR[31:24];
    assign accept   = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
    assign req_ram  = req_q.bank < BANK_W'(NBANKS);
    assign req_ctrl = req_q.bank == BANK_W'(NBANKS);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_ACCESS;
`ifdef WB_READBACK_EN
            S_ACCESS: state_d = (req_ram && !req_q.we) ? S_WAIT : S_ACK;
`else
            S_ACCESS: state_d = S_ACK;
`endif
            S_WAIT:   state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Port-0 strobes are decoded from the live bus in the accept cycle so the
    // registered pulse lands exactly in the ACCESS cycle.
    always_comb begin
        csb0_d   = '1;
        web0_d   = 1'b1;
        wmask0_d = '0;
        ack_d    = (state_d == S_ACK);
        rdata_d  = wbs_dat_o;
        wp_d     = wp_q;
        run_d    = run_q;
        if (accept) begin
            for (int b = 0; b < NBANKS; b++) begin
                if (in_bank == BANK_W'(b)) begin
                    if (wbs_we_i && !wp_q) begin
                        csb0_d[b] = 1'b0;
                        web0_d    = 1'b0;
                        wmask0_d  = wbs_sel_i;
                    end
`ifdef WB_READBACK_EN
                    else if (!wbs_we_i) csb0_d[b] = 1'b0;
`endif
                end
            end
        end
        case (state_q)
            S_ACCESS: begin
                rdata_d = '0;
                if (req_ctrl) begin
                    if (req_q.we && req_q.sel[0]) {run_d, wp_d} = req_q.dat[1:0];
                    else if (!req_q.we)           rdata_d = {30'b0, run_q, wp_q};
                end
            end
`ifdef WB_READBACK_EN
            S_WAIT: begin
                for (int b = 0; b < NBANKS; b++)
                    if (req_q.bank == BANK_W'(b)) rdata_d = dout0_v[b];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            ram_csb0_o   <= '1;
            ram_web0_o   <= 1'b1;
            ram_wmask0_o <= '0;
            wp_q         <= 1'b0;
            run_q        <= 1'b0;
            req_q        <= '0;
        end else begin
            wbs_ack_o    <= ack_d;
            wbs_dat_o    <= rdata_d;
            ram_csb0_o   <= csb0_d;
            ram_web0_o   <= web0_d;
            ram_wmask0_o <= wmask0_d;
            wp_q         <= wp_d;
            run_q        <= run_d;
            if (accept)
                req_q <= '{we: wbs_we_i, sel: wbs_sel_i, bank: in_bank,
                           word: wbs_adr_i[ADDR_W+1:2], dat: wbs_dat_i};
        end
    end

    assign ram_addr0_o = req_q.word;
    assign ram_din0_o  = req_q.dat;
    assign core_rst_no = run_q;

    // Fetch port: the macro answers one cycle after select, so the bank is
    // remembered to steer the returning data.
    assign core_bank   = core_addr_i[ADDR_W +: BANK_W];
    assign ram_addr1_o = core_addr_i[ADDR_W-1:0];

    for (genvar b = 0; b < NBANKS; b++) begin : g_csb1
        assign ram_csb1_o[b] = core_csb_i | (core_bank != BANK_W'(b)) | ~run_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)       fbank_q <= BANK_W'(NBANKS);
        else if (!core_csb_i) fbank_q <= core_bank;
    end

    always_comb begin
        core_dat_o = '0;
        for (int b = 0; b < NBANKS; b++)
            if (fbank_q == BANK_W'(b)) core_dat_o = dout1_v[b];
    end

    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i, req_q.sel[3:1], ram_dout0_i};

endmodule

// File: tb/tb_wb_sram_bank_loader.sv
// Directed bench for wb_sram_bank_loader with a behavioural 1rw1r SRAM model per bank.
module tb_wb_sram_bank_loader;
    localparam int NB = 2;
    localparam int AW = 9;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              cyc = 0, stb = 0, wbe = 0;
    logic [3:0]        sel_i = 0;
    logic [31:0]       adr_i = 0, dat_i = 0;
    logic              ack;
    logic [31:0]       wb_rdat;
    logic              core_csb = 1;
    logic [BW+AW-1:0]  core_addr = 0;
    logic [31:0]       core_dat;
    logic              core_rst_n;
    logic [NB-1:0]     ram_csb0, ram_csb1;
    logic              ram_web0;
    logic [3:0]        ram_wmask0;
    logic [AW-1:0]     ram_addr0, ram_addr1;
    logic [31:0]       ram_din0;
    logic [NB-1:0][31:0] dout0_r, dout1_r;

    wb_sram_bank_loader #(.NBANKS(NB), .ADDR_W(AW), .BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(wbe), .wbs_sel_i(sel_i),
        .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(wb_rdat),
        .core_csb_i(core_csb), .core_addr_i(core_addr), .core_dat_o(core_dat),
        .core_rst_no(core_rst_n),
        .ram_csb0_o(ram_csb0), .ram_web0_o(ram_web0), .ram_wmask0_o(ram_wmask0),
        .ram_addr0_o(ram_addr0), .ram_din0_o(ram_din0), .ram_dout0_i(dout0_r),
        .ram_csb1_o(ram_csb1), .ram_addr1_o(ram_addr1), .ram_dout1_i(dout1_r)
    );

    logic [31:0] mem [NB][1<<AW];
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!ram_csb0[b]) begin
                if (!ram_web0) begin
                    for (int k = 0; k < 4; k++)
                        if (ram_wmask0[k]) mem[b][ram_addr0][8*k +: 8] <= ram_din0[8*k +: 8];
                end else dout0_r[b] <= mem[b][ram_addr0];
            end
            if (!ram_csb1[b]) dout1_r[b] <= mem[b][ram_addr1];
        end
    end

    int ack_cnt = 0, onehot_err = 0;
    int pulse_cnt [NB];
    logic [AW-1:0] last_addr0;
    logic [3:0]    last_wmask;
    logic [31:0]   last_din0;
    logic          last_web0, rst_at_ack;
    initial for (int b = 0; b < NB; b++) pulse_cnt[b] = 0;

    always @(negedge clk) begin
        if (ack) begin
            ack_cnt++;
            rst_at_ack = core_rst_n;
        end
        if ($countones(~ram_csb0) > 1) onehot_err++;
        for (int b = 0; b < NB; b++)
            if (!ram_csb0[b]) begin
                pulse_cnt[b]++;
                last_addr0 = ram_addr0;
                last_wmask = ram_wmask0;
                last_din0  = ram_din0;
                last_web0  = ram_web0;
            end
    end

    int checks = 0, failures = 0;

`ifdef WB_READBACK_EN
    localparam int RD_LAT = 3;
    localparam bit RB     = 1'b1;
`else
    localparam int RD_LAT = 2;
    localparam bit RB     = 1'b0;
`endif

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output logic [31:0] rd);
        @(posedge clk); #1;
        cyc = 1; stb = 1; wbe = we; adr_i = adr; dat_i = dat; sel_i = sel;
        @(posedge clk);
        lat = 0;
        do begin
            lat++;
            @(negedge clk);
        end while (!ack && lat < 20);
        rd = wb_rdat;
        @(posedge clk); #1;
        cyc = 0; stb = 0; wbe = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b want=0", ack); end
        checks++; if (wb_rdat !== 32'h0) begin failures++; $display("FAIL rst_dat got=%h want=0", wb_rdat); end
        checks++; if (ram_csb0 !== 2'b11) begin failures++; $display("FAIL rst_csb0 got=%b want=11", ram_csb0); end
        checks++; if (ram_web0 !== 1'b1) begin failures++; $display("FAIL rst_web0 got=%b want=1", ram_web0); end
        checks++; if (ram_wmask0 !== 4'h0) begin failures++; $display("FAIL rst_wmask got=%h want=0", ram_wmask0); end
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL rst_core_rst got=%b want=0", core_rst_n); end
        checks++; if (ram_csb1 !== 2'b11) begin failures++; $display("FAIL rst_csb1 got=%b want=11", ram_csb1); end
        checks++; if (core_dat !== 32'h0) begin failures++; $display("FAIL rst_core_dat got=%h want=0", core_dat); end
        @(posedge clk); #1; rst_n = 1;
        core_csb = 0; core_addr = {2'd0, 9'd1};
        @(negedge clk);
        checks++; if (ram_csb1 !== 2'b11) begin failures++; $display("FAIL norun_csb1 got=%b want=11", ram_csb1); end
        @(posedge clk); #1; core_csb = 1;
    endtask

    task automatic test_write();
        int p0, p1, lat;
        logic [31:0] rd;
        p0 = pulse_cnt[0]; p1 = pulse_cnt[1];
        wb_xfer(1'b1, 32'h3000_0814, 32'hDEAD_BEEF, 4'hF, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL wr_lat got=%0d want=2", lat); end
        checks++; if (pulse_cnt[1] - p1 !== 1) begin failures++; $display("FAIL wr_pulse1 got=%0d want=1", pulse_cnt[1] - p1); end
        checks++; if (pulse_cnt[0] - p0 !== 0) begin failures++; $display("FAIL wr_pulse0 got=%0d want=0", pulse_cnt[0] - p0); end
        checks++; if (last_addr0 !== 9'd5) begin failures++; $display("FAIL wr_addr0 got=%0d want=5", last_addr0); end
        checks++; if (last_wmask !== 4'hF) begin failures++; $display("FAIL wr_wmask got=%h want=f", last_wmask); end
        checks++; if (last_web0 !== 1'b0) begin failures++; $display("FAIL wr_web0 got=%b want=0", last_web0); end
        checks++; if (last_din0 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_din got=%h want=deadbeef", last_din0); end
        checks++; if (mem[1][5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_mem got=%h want=deadbeef", mem[1][5]); end
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL wr_core_rst got=%b want=0", core_rst_n); end
        // partial byte-lane write over an existing word
        wb_xfer(1'b1, 32'h3000_0024, 32'h1111_1111, 4'hF, lat, rd);
        wb_xfer(1'b1, 32'h3000_0024, 32'hAABB_CCDD, 4'h3, lat, rd);
        checks++; if (last_wmask !== 4'h3) begin failures++; $display("FAIL pw_wmask got=%h want=3", last_wmask); end
        checks++; if (mem[0][9] !== 32'h1111_CCDD) begin failures++; $display("FAIL pw_mem got=%h want=1111ccdd", mem[0][9]); end
    endtask

    task automatic test_read();
        int p1, lat;
        logic [31:0] rd, exp;
        p1 = pulse_cnt[1];
        wb_xfer(1'b0, 32'h3000_0814, 32'h0, 4'hF, lat, rd);
        exp = RB ? 32'hDEAD_BEEF : 32'h0;
        checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL rd_lat got=%0d want=%0d", lat, RD_LAT); end
        checks++; if (rd !== exp) begin failures++; $display("FAIL rd_dat got=%h want=%h", rd, exp); end
        checks++; if (pulse_cnt[1] - p1 !== (RB ? 1 : 0)) begin failures++; $display("FAIL rd_pulse got=%0d want=%0d", pulse_cnt[1] - p1, RB ? 1 : 0); end
        wb_xfer(1'b0, 32'h3000_0024, 32'h0, 4'hF, lat, rd);
        exp = RB ? 32'h1111_CCDD : 32'h0;
        checks++; if (rd !== exp) begin failures++; $display("FAIL rd_pw got=%h want=%h", rd, exp); end
    endtask

    task automatic test_ctrl();
        int p0, lat;
        logic [31:0] rd;
        wb_xfer(1'b1, 32'h3000_081C, 32'h1234_5678, 4'hF, lat, rd);
        wb_xfer(1'b1, 32'h3000_001C, 32'hCAFE_F00D, 4'hF, lat, rd);
        wb_xfer(1'b1, 32'h3000_1000, 32'h0000_0003, 4'h1, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ctrl_lat got=%0d want=2", lat); end
        checks++; if (rst_at_ack !== 1'b1) begin failures++; $display("FAIL ctrl_run_at_ack got=%b want=1", rst_at_ack); end
        p0 = pulse_cnt[0];
        wb_xfer(1'b1, 32'h3000_0008, 32'h5555_5555, 4'hF, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL wp_lat got=%0d want=2", lat); end
        checks++; if (pulse_cnt[0] - p0 !== 0) begin failures++; $display("FAIL wp_pulse got=%0d want=0", pulse_cnt[0] - p0); end
        // CTRL ignores writes that leave byte lane 0 disabled
        wb_xfer(1'b1, 32'h3000_1000, 32'h0000_0000, 4'hE, lat, rd);
        wb_xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ctrl_rd_lat got=%0d want=2", lat); end
        checks++; if (rd !== 32'h3) begin failures++; $display("FAIL ctrl_rd got=%h want=3", rd); end
    endtask

    task automatic test_fetch();
        @(posedge clk); #1; core_csb = 0; core_addr = {2'd1, 9'd7};
        @(negedge clk);
        checks++; if (ram_csb1 !== 2'b01) begin failures++; $display("FAIL f1_csb1 got=%b want=01", ram_csb1); end
        checks++; if (ram_addr1 !== 9'd7) begin failures++; $display("FAIL f1_addr1 got=%0d want=7", ram_addr1); end
        @(posedge clk); #1; core_addr = {2'd0, 9'd7};
        @(negedge clk);
        checks++; if (core_dat !== 32'h1234_5678) begin failures++; $display("FAIL f1_dat got=%h want=12345678", core_dat); end
        checks++; if (ram_csb1 !== 2'b10) begin failures++; $display("FAIL f0_csb1 got=%b want=10", ram_csb1); end
        @(posedge clk); #1; core_addr = {2'd2, 9'd7};
        @(negedge clk);
        checks++; if (core_dat !== 32'hCAFE_F00D) begin failures++; $display("FAIL f0_dat got=%h want=cafef00d", core_dat); end
        checks++; if (ram_csb1 !== 2'b11) begin failures++; $display("FAIL f2_csb1 got=%b want=11", ram_csb1); end
        @(posedge clk); #1; core_csb = 1;
        @(negedge clk);
        checks++; if (core_dat !== 32'h0) begin failures++; $display("FAIL f2_dat got=%h want=0", core_dat); end
    endtask

    task automatic test_out_of_range();
        int p0, p1, a0, lat;
        logic [31:0] rd;
        p0 = pulse_cnt[0]; p1 = pulse_cnt[1]; a0 = ack_cnt;
        wb_xfer(1'b0, 32'h3000_1814, 32'h0, 4'hF, lat, rd);
        repeat (3) @(posedge clk);
        checks++; if (lat !== 2) begin failures++; $display("FAIL oor_lat got=%0d want=2", lat); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL oor_dat got=%h want=0", rd); end
        checks++; if (ack_cnt - a0 !== 1) begin failures++; $display("FAIL oor_ack_count got=%0d want=1", ack_cnt - a0); end
        wb_xfer(1'b1, 32'h3000_1814, 32'hFFFF_FFFF, 4'hF, lat, rd);
        checks++; if (lat !== 2) begin failures++; $display("FAIL oor_wr_lat got=%0d want=2", lat); end
        checks++; if (pulse_cnt[0] + pulse_cnt[1] - p0 - p1 !== 0) begin failures++; $display("FAIL oor_pulse got=%0d want=0", pulse_cnt[0] + pulse_cnt[1] - p0 - p1); end
        // a miss on BASE_ADDR[31:24] must never be acked
        a0 = ack_cnt;
        @(posedge clk); #1; cyc = 1; stb = 1; wbe = 0; adr_i = 32'h2000_0814;
        repeat (6) @(posedge clk); #1; cyc = 0; stb = 0;
        checks++; if (ack_cnt - a0 !== 0) begin failures++; $display("FAIL miss_ack got=%0d want=0", ack_cnt - a0); end
    endtask

    task automatic test_reset_mid();
        int a0, lat;
        logic [31:0] rd;
        @(posedge clk); #1;
        cyc = 1; stb = 1; wbe = 0; adr_i = 32'h3000_0814; sel_i = 4'hF;
        core_csb = 0; core_addr = {2'd1, 9'd5};
        a0 = ack_cnt;
        @(posedge clk);
        if (RB) @(posedge clk);
        #1;
        checks++; if (ram_csb1 !== 2'b01) begin failures++; $display("FAIL mid_pre_csb1 got=%b want=01", ram_csb1); end
        rst_n = 0;
        #1;
        checks++; if (ram_csb1 !== 2'b11) begin failures++; $display("FAIL mid_csb1 got=%b want=11", ram_csb1); end
        checks++; if (ram_csb0 !== 2'b11) begin failures++; $display("FAIL mid_csb0 got=%b want=11", ram_csb0); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL mid_ack got=%b want=0", ack); end
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL mid_core_rst got=%b want=0", core_rst_n); end
        repeat (3) @(posedge clk); #1;
        cyc = 0; stb = 0; core_csb = 1; rst_n = 1;
        repeat (3) @(posedge clk);
        checks++; if (ack_cnt - a0 !== 0) begin failures++; $display("FAIL mid_ack_count got=%0d want=0", ack_cnt - a0); end
        wb_xfer(1'b0, 32'h3000_1000, 32'h0, 4'hF, lat, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_ctrl got=%h want=0", rd); end
        checks++; if (onehot_err !== 0) begin failures++; $display("FAIL csb0_onehot got=%0d want=0", onehot_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_write();
        test_read();
        test_ctrl();
        test_fetch();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_sram_bank_loader.md
# wb_sram_bank_loader

Parametrised Wishbone-to-SRAM loader that fronts NBANKS OpenRAM 1rw1r 32-bit macros.
- Port 0 of every macro serves the management SoC over Wishbone for program load and readback.
- Port 1 of every macro serves the core's instruction fetch.
- A control word gates the core's reset and write-protects the program store after load.
- Sits in user_project_wrapper between the Wishbone slave pins, the SRAM macros and the CPU core wrapper, and replaces direct macro wiring.

## Interface
- NBANKS, 2, number of 32xDEPTH SRAM macros (1..7)
- ADDR_W, 9, word-address width per macro (DEPTH = 2^ADDR_W)
- BASE_ADDR, 32'h3000_0000, Wishbone base; the request hits when wbs_adr_i[31:24] == BASE_ADDR[31:24]
- wb_clk_i  in  1  single clock; the SRAM macros use the same clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic strobes
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i, wbs_dat_i  in  32  byte address / write data
- wbs_ack_o  out  1  single-cycle ack
- wbs_dat_o  out  32  read data, valid with ack
- core_csb_i  in  1  core fetch enable, active low
- core_addr_i  in  BANK_W+ADDR_W  fetch word address, bank in the MSBs; BANK_W = clog2(NBANKS+1)
- core_dat_o  out  32  fetch data
- core_rst_no  out  1  core reset, active low
- ram_csb0_o  out  NBANKS  port-0 chip select per bank, active low
- ram_web0_o  out  1  port-0 write enable, active low
- ram_wmask0_o  out  4  port-0 write byte mask
- ram_addr0_o  out  ADDR_W  port-0 address
- ram_din0_o  out  32  port-0 write data
- ram_dout0_i  in  NBANKS*32  port-0 read data, bank b in [32b+31:32b]
- ram_csb1_o  out  NBANKS  port-1 chip select per bank, active low
- ram_addr1_o  out  ADDR_W  port-1 address
- ram_dout1_i  in  NBANKS*32  port-1 read data

## Operation
- Address decode:
  - word = wbs_adr_i[ADDR_W+1:2]
  - bank = wbs_adr_i[ADDR_W+2 +: BANK_W]
  - bank == NBANKS selects the control register CTRL.
  - bank > NBANKS is out of range.
- CTRL fields:
  - bit0 WP: write protect.
  - bit1 RUN: drives core_rst_no.
  - Reset value 0: core held in reset, store writable.
  - CTRL is written with byte lane 0 only and reads back {30'b0, RUN, WP}.
- FSM states: IDLE, ACCESS, WAIT, ACK.
  - IDLE -> ACCESS: cyc&stb&hit while wbs_ack_o is low. Address, data, sel and we are latched.
  - ACCESS, bank write with WP=0: one-cycle pulse csb0[bank]=0, web0=0, wmask0=sel. Next state ACK.
  - ACCESS, bank write with WP=1: no SRAM access. Next state ACK.
  - ACCESS, bank read: csb0[bank]=0, web0=1 for one cycle. Next state WAIT.
  - WAIT: capture ram_dout0_i[bank] into the read-data register. Next state ACK.
  - ACCESS, CTRL or out-of-range: update CTRL on a CTRL write, load the read data. Next state ACK.
  - Out-of-range accesses read 32'h0 and drop writes.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE.
- Only one SRAM chip-select bit is low in any cycle. All port-0 outputs are registered.
- Fetch port:
  - ram_addr1_o = core_addr_i[ADDR_W-1:0].
  - ram_csb1_o[b] = core_csb_i | (core_addr_i bank != b) | ~RUN.
  - The bank select is registered on every cycle with csb low.
  - core_dat_o = ram_dout1_i of the registered bank; 0 if that bank is ≥ NBANKS.
- Reset mid-transaction: the FSM returns to IDLE, ack is dropped, CTRL is cleared and the core is held in reset. The master must retry.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, ram_csb0_o all 1, ram_web0_o=1, ram_wmask0_o=0.
  - core_rst_no=0, ram_csb1_o all 1, core_dat_o=0.
- Latency, counted from the cycle where cyc&stb are sampled in IDLE:
  - ack at +2 for writes, CTRL accesses and out-of-range accesses.
  - ack at +3 for SRAM reads.
- A strobe still high in the ack cycle is not re-accepted. The next request is accepted at the earliest in the cycle after ack.
- core_rst_no follows a RUN write one cycle after the ACCESS cycle, coincident with ack.
- Fetch data is valid one cycle after core_csb_i is sampled low, following the macro read latency.

## Configuration
- WB_READBACK_EN defined:
  - Bank reads follow ACCESS -> WAIT -> ACK and return SRAM data.
  - Port-0 reads are issued.
- WB_READBACK_EN undefined:
  - Bank reads skip the SRAM (ACCESS -> ACK, latency +2), return 32'h0 and never assert csb0.
  - WAIT and ram_dout0_i are unused.
  - CTRL readback is unaffected.

## Test plan
- Reset, then write 32'hDEAD_BEEF with sel=4'hF to bank 1, word 5 → single csb0[1]=0/web0=0 pulse with addr0=5 and wmask0=F; ack at +2; core_rst_no stays 0.
- Read bank 1, word 5 (WB_READBACK_EN, model returns DEAD_BEEF) → ack at +3 with wbs_dat_o=32'hDEAD_BEEF; with the macro undefined, ack at +2 with data 0.
- Write CTRL=3, then write bank 0 → core_rst_no=1 on the ack cycle; the bank write is acked with no csb0 pulse; CTRL read returns 32'h3.
- With RUN=1, drive core_csb_i=0 and core_addr_i = bank 1, word 7 → only csb1[1] low; the next cycle core_dat_o equals the model's bank-1 data.
- Access bank NBANKS+1 → ack at +2, data 0, no csb0 activity; hold stb high through ack → exactly one ack.
- Assert wb_rst_ni low in the WAIT state → ack never asserted; CTRL=0; all csb outputs high immediately.
